// File: rtl/reg_ul_bank.sv
// reg_ul_bank: user-logic register bank on an MPI-style cpu_wr/cpu_rd bus.
//
// Holds the version words, a scratch register (read back inverted), the
// vLED drive register, control/status, an unmapped-access error counter
// and NUM_CH operand-pair adder channels. A start command runs a small
// IDLE -> CALC -> DONE state machine that sums one channel per cycle.
//
// Ports:
//   clks          clock
//   reset_n       asynchronous active-low reset, clears every flop
//   cpu_wr        write strobe (one cycle per write)
//   cpu_rd        read strobe (one cycle per read)
//   cpu_addr      word address shared by reads and writes
//   cpu_data_in   write data
//   cpu_data_out  registered read data, held until the next read
//   cpu_rd_vld    one-cycle strobe, cpu_data_out valid
//   ul2sh_vled    virtual LED drive
//   calc_done     one-cycle pulse while the state machine is in DONE
//
// Build option:
//   REG_UL_SAT_EN  when defined, channel sums saturate to all-ones on
//                  carry-out and status bit4 reports the capability.
//                  When undefined, sums wrap and status bit4 reads 0.
module reg_ul_bank #(
  parameter int CPU_ADDR_WIDTH = 12,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int NUM_CH         = 4,
  parameter int VLED_WIDTH     = 16,
  parameter logic [CPU_DATA_WIDTH-1:0] VER_TIME = 32'h2018_0301,
  parameter logic [CPU_DATA_WIDTH-1:0] VER_TYPE = 32'h00D1_0007
) (
  input  logic                      clks,
  input  logic                      reset_n,
  input  logic                      cpu_wr,
  input  logic                      cpu_rd,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
  output logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
  output logic                      cpu_rd_vld,
  output logic [VLED_WIDTH-1:0]     ul2sh_vled,
  output logic                      calc_done
);

  localparam int AW   = CPU_ADDR_WIDTH;
  localparam int DW   = CPU_DATA_WIDTH;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [AW-1:0] A_VER_TIME = AW'(0);
  localparam logic [AW-1:0] A_VER_TYPE = AW'(1);
  localparam logic [AW-1:0] A_SCRATCH  = AW'(2);
  localparam logic [AW-1:0] A_VLED     = AW'(3);
  localparam logic [AW-1:0] A_CTRL     = AW'(4);
  localparam logic [AW-1:0] A_STATUS   = AW'(5);
  localparam logic [AW-1:0] A_ERR      = AW'(6);
  localparam logic [AW-1:0] A_CH_BASE  = AW'(16);
  localparam logic [AW-1:0] A_CH_END   = AW'(16 + 4 * NUM_CH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef REG_UL_SAT_EN
  localparam logic SAT_CAP = 1'b1;
`else
  localparam logic SAT_CAP = 1'b0;
`endif

  // Full-width add with the carry kept in the top bit.
  function automatic logic [DW:0] add_carry(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Saturates to all-ones on carry-out when the capability is built in,
  // otherwise passes the wrapped low bits through.
  function automatic logic [DW-1:0] sat_sum(input logic [DW:0] s);
    return s[DW-1:0] | {DW{s[DW] & SAT_CAP}};
  endfunction

  logic [1:0]            state_q, state_d;
  logic [CH_W-1:0]       idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  drop_q, drop_d;
  logic [DW-1:0]         scratch_q, scratch_d;
  logic [VLED_WIDTH-1:0] vled_q, vled_d;
  logic [DW-1:0]         err_cnt_q, err_cnt_d;
  logic [DW-1:0]         rd_data_q, rd_data_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [DW-1:0]         op_a_q [NUM_CH];
  logic [DW-1:0]         op_a_d [NUM_CH];
  logic [DW-1:0]         op_b_q [NUM_CH];
  logic [DW-1:0]         op_b_d [NUM_CH];
  logic [DW-1:0]         sum_q  [NUM_CH];
  logic [DW-1:0]         sum_d  [NUM_CH];
  logic [DW-1:0]         ops_q  [NUM_CH];
  logic [DW-1:0]         ops_d  [NUM_CH];

  logic                  ch_hit;
  logic [CH_W-1:0]       ch_sel;
  logic                  start;
  logic                  rd_err;
  logic                  wr_err;
  logic [DW+1:0]         err_next;
  logic [DW:0]           add_res;

  // Channel window is 4-word aligned, so addr[1:0] is the register offset.
  assign ch_hit = (cpu_addr >= A_CH_BASE) && (cpu_addr < A_CH_END);
  assign ch_sel = CH_W'((cpu_addr - A_CH_BASE) >> 2);
  assign add_res = add_carry(op_a_q[idx_q], op_b_q[idx_q]);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    scratch_d = scratch_q;
    vled_d    = vled_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = cpu_rd;
    start     = 1'b0;
    rd_err    = 1'b0;
    wr_err    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      op_a_d[i] = op_a_q[i];
      op_b_d[i] = op_b_q[i];
      sum_d[i]  = sum_q[i];
      ops_d[i]  = ops_q[i];
    end

    // Read path samples current register state, so a same-cycle write is
    // not visible until the next read.
    if (cpu_rd) begin
      rd_data_d = '0;
      if (ch_hit) begin
        case (cpu_addr[1:0])
          2'd0:    rd_data_d = op_a_q[ch_sel];
          2'd1:    rd_data_d = op_b_q[ch_sel];
          2'd2:    rd_data_d = sum_q[ch_sel];
          default: rd_data_d = ops_q[ch_sel];
        endcase
      end else begin
        case (cpu_addr)
          A_VER_TIME: rd_data_d = VER_TIME;
          A_VER_TYPE: rd_data_d = VER_TYPE;
          A_SCRATCH:  rd_data_d = ~scratch_q;
          A_VLED:     rd_data_d = DW'(vled_q);
          A_CTRL:     rd_data_d = '0;
          A_STATUS:   rd_data_d = DW'({SAT_CAP, drop_q, ovf_q, done_q, busy_q});
          A_ERR:      rd_data_d = err_cnt_q;
          default:    rd_err    = 1'b1;
        endcase
      end
    end

    if (cpu_wr) begin
      if (ch_hit) begin
        case (cpu_addr[1:0])
          2'd0: begin
            if (busy_q) drop_d = 1'b1;
            else        op_a_d[ch_sel] = cpu_data_in;
          end
          2'd1: begin
            if (busy_q) drop_d = 1'b1;
            else        op_b_d[ch_sel] = cpu_data_in;
          end
          default: wr_err = 1'b1;
        endcase
      end else begin
        case (cpu_addr)
          A_SCRATCH: scratch_d = cpu_data_in;
          A_VLED:    vled_d    = cpu_data_in[VLED_WIDTH-1:0];
          A_CTRL: begin
            if (cpu_data_in[0]) begin
              if (busy_q) drop_d = 1'b1;
              else        start  = 1'b1;
            end
          end
          A_STATUS: begin
            if (cpu_data_in[1]) done_d = 1'b0;
            if (cpu_data_in[2]) ovf_d  = 1'b0;
            if (cpu_data_in[3]) drop_d = 1'b0;
          end
          default: wr_err = 1'b1;
        endcase
      end
    end

    // A read and a write can both miss in one cycle; count both, saturating.
    err_next  = (DW+2)'(err_cnt_q) + (DW+2)'(rd_err) + (DW+2)'(wr_err);
    err_cnt_d = (err_next[DW+1:DW] != 2'b00) ? {DW{1'b1}} : err_next[DW-1:0];

    // State machine runs after the bus so its status sets override a
    // coincident W1C.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CALC;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      ST_CALC: begin
        sum_d[idx_q] = sat_sum(add_res);
        ops_d[idx_q] = ops_q[idx_q] + DW'(1);
        if (add_res[DW]) ovf_d = 1'b1;
        if (idx_q == CH_W'(NUM_CH - 1)) state_d = ST_DONE;
        else                            idx_d   = idx_q + CH_W'(1);
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clks or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= 1'b0;
      scratch_q <= '0;
      vled_q    <= '0;
      err_cnt_q <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
        sum_q[i]  <= '0;
        ops_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
      scratch_q <= scratch_d;
      vled_q    <= vled_d;
      err_cnt_q <= err_cnt_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      for (int i = 0; i < NUM_CH; i++) begin
        op_a_q[i] <= op_a_d[i];
        op_b_q[i] <= op_b_d[i];
        sum_q[i]  <= sum_d[i];
        ops_q[i]  <= ops_d[i];
      end
    end
  end

  assign cpu_data_out = rd_data_q;
  assign cpu_rd_vld   = rd_vld_q;
  assign ul2sh_vled   = vled_q;
  assign calc_done    = (state_q == ST_DONE);

endmodule
